// File: rtl/frame_renderer.sv
// VGA frame renderer: beam counters, a once-per-frame snapshot of game state,
// and a two-stage pixel pipeline (hit tests, then colour select).
module frame_renderer #(
   parameter int   H_VISIBLE   = 800,
   parameter int   H_FRONT     = 40,
   parameter int   H_SYNC      = 128,
   parameter int   H_BACK      = 88,
   parameter int   V_VISIBLE   = 600,
   parameter int   V_FRONT     = 1,
   parameter int   V_SYNC      = 4,
   parameter int   V_BACK      = 23,
   parameter logic SYNC_ACTIVE = 1'b1,
   parameter int   WALL_PIXEL  = 16,
   parameter int   BLOCK_X0    = 16,
   parameter int   BLOCK_Y0    = 64,
   parameter int   PADDLE_Y    = 560,
   parameter int   PADDLE_LEN  = 60,
   parameter int   PADDLE_H    = 8,
   parameter int   BALL_SIZE   = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [9:0]  BALL_X_PIXEL,
   input  logic [9:0]  BALL_Y_PIXEL,
   input  logic [9:0]  PADDLE_X_PIXEL,
   input  logic [71:0] BLOCK_STATE,
   output logic        START_UPDATE,
   output logic        HSYNC,
   output logic        VSYNC,
   output logic [2:0]  RED,
   output logic [2:0]  GREEN,
   output logic [1:0]  BLUE
);
   localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
   localparam logic [10:0] H_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
   localparam logic [10:0] V_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [10:0] WALL_L  = 11'(WALL_PIXEL);
   localparam logic [10:0] WALL_R  = 11'(H_VISIBLE - WALL_PIXEL);
   localparam logic [10:0] BX0     = 11'(BLOCK_X0);
   localparam logic [10:0] BY0     = 11'(BLOCK_Y0);
   localparam logic [10:0] PAD_Y0  = 11'(PADDLE_Y);
   localparam logic [10:0] PAD_Y1  = 11'(PADDLE_Y + PADDLE_H);
   localparam logic [10:0] PAD_LEN = 11'(PADDLE_LEN);
   localparam logic [10:0] BALL_SZ = 11'(BALL_SIZE);

   function automatic logic [7:0] row_colour(input logic [2:0] row);
      case (row)
         3'd0:    row_colour = 8'b111_000_00;
         3'd1:    row_colour = 8'b111_100_00;
         3'd2:    row_colour = 8'b111_111_00;
         3'd3:    row_colour = 8'b000_111_00;
         3'd4:    row_colour = 8'b000_000_11;
         default: row_colour = 8'b111_000_11;
      endcase
   endfunction

   function automatic logic [7:0] pix_colour(input logic vld, input logic ball,
                                             input logic pad, input logic blk,
                                             input logic wall, input logic [2:0] row);
      if (!vld)      pix_colour = 8'h00;
      else if (ball) pix_colour = 8'b111_111_11;
      else if (pad)  pix_colour = 8'b000_111_11;
      else if (blk)  pix_colour = row_colour(row);
      else if (wall) pix_colour = 8'b100_100_10;
      else           pix_colour = 8'h00;
   endfunction

   logic [10:0] h_q, h_d, v_q, v_d;
   logic [9:0]  ball_x_q, ball_y_q, pad_x_q;
   logic [71:0] blk_q;
   logic        snap;
   logic [9:0]  bx, by;
   logic [3:0]  col;
   logic [5:0]  row;
   logic [6:0]  idx;
   logic [10:0] ball_x, ball_y, pad_x;
   logic        vld_p1_d, hs_p1_d, vs_p1_d, ball_p1_d, pad_p1_d, blk_p1_d, wall_p1_d;
   logic        vld_p1_q, hs_p1_q, vs_p1_q, ball_p1_q, pad_p1_q, blk_p1_q, wall_p1_q;
   logic [2:0]  row_p1_q;
   logic [7:0]  rgb_p2_q;
   logic        hs_p2_q, vs_p2_q;

   always_comb begin
      h_d = h_q + 11'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end
   end

   // Stage 0: beam position decode, read against the frame's shadow copy
   assign START_UPDATE = (h_q == '0) && (v_q == V_VIS);
   assign snap         = (h_q == '0) && (v_q == V_LAST);

   assign vld_p1_d = (h_q < H_VIS) && (v_q < V_VIS);
   assign hs_p1_d  = (h_q >= HS_BEG) && (h_q < HS_END);
   assign vs_p1_d  = (v_q >= VS_BEG) && (v_q < VS_END);

   // Above or left of the block area the subtraction wraps to a row/col that fails the range test
   assign bx  = 10'(h_q - BX0);
   assign by  = 10'(v_q - BY0);
   assign col = bx[9:6];
   assign row = by[9:4];
   assign idx = 7'({row[2:0], 3'b000}) + 7'({row[2:0], 2'b00}) + 7'(col);
   assign blk_p1_d = (h_q >= BX0) && (col < 4'd12) && (row < 6'd6) && blk_q[idx]
                     && (bx[5:0] != 6'h3F) && (by[3:0] != 4'hF);

   assign ball_x = {1'b0, ball_x_q};
   assign ball_y = {1'b0, ball_y_q};
   assign pad_x  = {1'b0, pad_x_q};
   assign ball_p1_d = (h_q >= ball_x) && (h_q < ball_x + BALL_SZ)
                      && (v_q >= ball_y) && (v_q < ball_y + BALL_SZ);
   assign pad_p1_d  = (h_q >= pad_x) && (h_q < pad_x + PAD_LEN)
                      && (v_q >= PAD_Y0) && (v_q < PAD_Y1);
   assign wall_p1_d = (h_q < WALL_L) || (h_q >= WALL_R) || (v_q < WALL_L);

   always_ff @(posedge CLK) begin
      if (RST) begin
         h_q       <= '0;
         v_q       <= '0;
         ball_x_q  <= '0;
         ball_y_q  <= '0;
         pad_x_q   <= '0;
         blk_q     <= '0;
         vld_p1_q  <= 1'b0;
         hs_p1_q   <= 1'b0;
         vs_p1_q   <= 1'b0;
         ball_p1_q <= 1'b0;
         pad_p1_q  <= 1'b0;
         blk_p1_q  <= 1'b0;
         wall_p1_q <= 1'b0;
         row_p1_q  <= '0;
         rgb_p2_q  <= '0;
         hs_p2_q   <= ~SYNC_ACTIVE;
         vs_p2_q   <= ~SYNC_ACTIVE;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         if (snap) begin
            ball_x_q <= BALL_X_PIXEL;
            ball_y_q <= BALL_Y_PIXEL;
            pad_x_q  <= PADDLE_X_PIXEL;
            blk_q    <= BLOCK_STATE;
         end
         // Stage 1: registered hit flags
         vld_p1_q  <= vld_p1_d;
         hs_p1_q   <= hs_p1_d;
         vs_p1_q   <= vs_p1_d;
         ball_p1_q <= ball_p1_d;
         pad_p1_q  <= pad_p1_d;
         blk_p1_q  <= blk_p1_d;
         wall_p1_q <= wall_p1_d;
         row_p1_q  <= row[2:0];
         // Stage 2: colour select and sync polarity
         rgb_p2_q <= pix_colour(vld_p1_q, ball_p1_q, pad_p1_q, blk_p1_q, wall_p1_q, row_p1_q);
         hs_p2_q  <= hs_p1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vs_p2_q  <= vs_p1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
   end

   assign HSYNC = hs_p2_q;
   assign VSYNC = vs_p2_q;
   assign RED   = rgb_p2_q[7:5];
   assign GREEN = rgb_p2_q[4:2];
   assign BLUE  = rgb_p2_q[1:0];
endmodule

// File: tb/tb_frame_renderer.sv
// Bench for frame_renderer on a reduced raster; every output is compared each cycle
// against a pixel-rule model indexed by cycles since reset release.
module tb_frame_renderer;
   localparam int HV = 160, HF = 4, HS = 8, HB = 4, HT = HV + HF + HS + HB;
   localparam int VV = 100, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam int WP = 16, BX0 = 16, BY0 = 4, PY = 90, PL = 60, PH = 8, BS = 8;
   localparam int NDIR = 9;

   typedef struct {
      int         x;
      int         y;
      logic [7:0] rgb;
      logic       hs;
      logic       vs;
   } px_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic [9:0]  bx_i, by_i, px_i;
   logic [71:0] blk_i;
   logic        START_UPDATE, HSYNC, VSYNC;
   logic [2:0]  RED, GREEN;
   logic [1:0]  BLUE;

   int          checks = 0;
   int          errors = 0;
   int          k;
   px_t         q[$];
   int          starts[$];
   logic [71:0] sh_blk;
   int          sh_bx, sh_by, sh_px;
   bit          jitter, dir_on;
   int          dir_hits;

   int         dx [NDIR] = '{0, 16, 79, 80, 102, 41, 26, 5, 158};
   int         dy [NDIR] = '{0, 4, 20, 20, 52, 91, 89, 50, 52};
   logic [7:0] dc [NDIR] = '{8'h92, 8'hE0, 8'h00, 8'hF0, 8'hFF, 8'h1F, 8'hE3, 8'h92, 8'h1C};

   frame_renderer #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE(1'b1), .WALL_PIXEL(WP), .BLOCK_X0(BX0), .BLOCK_Y0(BY0),
      .PADDLE_Y(PY), .PADDLE_LEN(PL), .PADDLE_H(PH), .BALL_SIZE(BS)
   ) dut (
      .CLK(CLK), .RST(RST),
      .BALL_X_PIXEL(bx_i), .BALL_Y_PIXEL(by_i), .PADDLE_X_PIXEL(px_i),
      .BLOCK_STATE(blk_i), .START_UPDATE(START_UPDATE),
      .HSYNC(HSYNC), .VSYNC(VSYNC), .RED(RED), .GREEN(GREEN), .BLUE(BLUE)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] row_rgb(input int r);
      case (r)
         0: return 8'hE0;
         1: return 8'hF0;
         2: return 8'hFC;
         3: return 8'h1C;
         4: return 8'h03;
         default: return 8'hE3;
      endcase
   endfunction

   function automatic logic [7:0] model_rgb(input int x, input int y);
      int c, r;
      if (x >= HV || y >= VV) return 8'h00;
      if (x >= sh_bx && x < sh_bx + BS && y >= sh_by && y < sh_by + BS) return 8'hFF;
      if (x >= sh_px && x < sh_px + PL && y >= PY && y < PY + PH) return 8'h1F;
      if (x >= BX0 && y >= BY0) begin
         c = (x - BX0) / 64;
         r = (y - BY0) / 16;
         if (c < 12 && r < 6 && sh_blk[r * 12 + c] && (x - BX0) % 64 != 63 && (y - BY0) % 16 != 15)
            return row_rgb(r);
      end
      if (x < WP || x >= HV - WP || y < WP) return 8'h92;
      return 8'h00;
   endfunction

   task automatic tick();
      int         hc, vc;
      px_t        m, e;
      logic [7:0] exp_rgb;
      logic       exp_hs, exp_vs, exp_st;
      bit         popped;
      hc = k % HT;
      vc = (k / HT) % VT;
      m.x   = hc;
      m.y   = vc;
      m.rgb = model_rgb(hc, vc);
      m.hs  = (hc >= HV + HF) && (hc < HV + HF + HS);
      m.vs  = (vc >= VV + VF) && (vc < VV + VF + VS);
      q.push_back(m);
      exp_rgb = 8'h00;
      exp_hs  = 1'b0;
      exp_vs  = 1'b0;
      popped  = 1'b0;
      e       = m;
      if (q.size() > 2) begin
         e       = q.pop_front();
         exp_rgb = e.rgb;
         exp_hs  = e.hs;
         exp_vs  = e.vs;
         popped  = 1'b1;
      end
      exp_st = (hc == 0) && (vc == VV);

      checks++;
      assert ({RED, GREEN, BLUE} === exp_rgb) else begin
         errors++;
         $error("FAIL rgb k=%0d got %h exp %h", k, {RED, GREEN, BLUE}, exp_rgb);
      end
      checks++;
      assert (HSYNC === exp_hs) else begin
         errors++;
         $error("FAIL hsync k=%0d got %b exp %b", k, HSYNC, exp_hs);
      end
      checks++;
      assert (VSYNC === exp_vs) else begin
         errors++;
         $error("FAIL vsync k=%0d got %b exp %b", k, VSYNC, exp_vs);
      end
      checks++;
      assert (START_UPDATE === exp_st) else begin
         errors++;
         $error("FAIL start k=%0d got %b exp %b", k, START_UPDATE, exp_st);
      end
      if (START_UPDATE === 1'b1) starts.push_back(k);

      if (dir_on && popped) begin
         for (int i = 0; i < NDIR; i++) begin
            if (e.x == dx[i] && e.y == dy[i]) begin
               dir_hits++;
               checks++;
               assert ({RED, GREEN, BLUE} === dc[i]) else begin
                  errors++;
                  $error("FAIL pix(%0d,%0d) got %h exp %h", dx[i], dy[i], {RED, GREEN, BLUE}, dc[i]);
               end
            end
         end
      end

      if (jitter && $urandom_range(7) == 0) begin
         bx_i  = 10'($urandom_range(1023));
         by_i  = 10'($urandom_range(1023));
         px_i  = 10'($urandom_range(1023));
         blk_i = {8'($urandom), $urandom, $urandom};
      end
      if (hc == 0 && vc == VT - 1) begin
         sh_blk = blk_i;
         sh_bx  = int'(bx_i);
         sh_by  = int'(by_i);
         sh_px  = int'(px_i);
      end

      @(posedge CLK);
      if (RST) begin
         k = 0;
         q.delete();
         starts.delete();
         sh_blk = '0;
         sh_bx  = 0;
         sh_by  = 0;
         sh_px  = 0;
      end else begin
         k++;
      end
      #1;
   endtask

   task automatic run_until(input int tk);
      int g;
      g = 0;
      while (k < tk) begin
         tick();
         g++;
         if (g > 90000) begin
            errors++;
            $display("FAIL run_until bound k=%0d target=%0d", k, tk);
            break;
         end
      end
   endtask

   initial begin
      int s0, s1;
      RST    = 1'b1;
      bx_i   = '0;
      by_i   = '0;
      px_i   = '0;
      blk_i  = '0;
      jitter = 1'b0;
      dir_on = 1'b0;
      dir_hits = 0;
      sh_blk = '0;
      sh_bx  = 0;
      sh_by  = 0;
      sh_px  = 0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      assert ({RED, GREEN, BLUE} === 8'h00) else begin
         errors++; $error("FAIL rst_rgb got %h exp 00", {RED, GREEN, BLUE});
      end
      checks++;
      assert (HSYNC === 1'b0 && VSYNC === 1'b0) else begin
         errors++; $error("FAIL rst_sync got %b%b exp 00", HSYNC, VSYNC);
      end
      checks++;
      assert (START_UPDATE === 1'b0) else begin
         errors++; $error("FAIL rst_start got %b exp 0", START_UPDATE);
      end

      // Frame 0: reset shadow on screen while inputs wander
      RST    = 1'b0;
      k      = 0;
      jitter = 1'b1;
      run_until(VV * HT + 2 * HT);

      // Frame 1: directed scene, ball moved mid-frame must not show yet
      jitter = 1'b0;
      blk_i  = {72{1'b1}};
      bx_i   = 10'd100;
      by_i   = 10'd50;
      px_i   = 10'd40;
      dir_on = 1'b1;
      run_until(FR + 50 * HT);
      bx_i   = 10'd156;
      run_until(FR + VV * HT + HT);
      dir_on = 1'b0;

      checks++;
      assert (dir_hits == NDIR) else begin
         errors++; $error("FAIL dir_hits got %0d exp %0d", dir_hits, NDIR);
      end
      s0 = (starts.size() > 0) ? starts[0] : -1;
      s1 = (starts.size() > 1) ? starts[1] - starts[0] : -1;
      checks++;
      assert (s0 == VV * HT) else begin
         errors++; $error("FAIL first_start got %0d exp %0d", s0, VV * HT);
      end
      checks++;
      assert (s1 == FR) else begin
         errors++; $error("FAIL start_period got %0d exp %0d", s1, FR);
      end

      // Frame 2: random blocks/paddle, ball clipped at the right edge
      blk_i = {8'($urandom), $urandom, $urandom};
      by_i  = 10'($urandom_range(VV - 1));
      px_i  = 10'($urandom_range(150));
      run_until(2 * FR + 30 * HT);

      RST = 1'b1;
      repeat (5) tick();
      RST = 1'b0;
      run_until(VV * HT + 2 * HT);

      s0 = (starts.size() == 1) ? starts[0] : -1;
      checks++;
      assert (s0 == VV * HT) else begin
         errors++; $error("FAIL restart_start got %0d exp %0d", s0, VV * HT);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
